spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Shares one single-SPI serial memory (cmd 0x03 read / 0x02 write, 16-bit address, 16-bit word) between the CPU instruction-fetch port and the data load/store port. It contains the only SPI master engine on that bus. It arbitrates round-robin between the two requesters, runs one complete transaction per grant, and returns read data with a one-cycle acknowledge. It sits between the core's fetch/LSU units and the pad-level SPI signals.

## Interface
- CS_HIGH_CYCLES, 2: minimum clk cycles CS stays high between transactions; legal values ≥2.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- fetch_req  in  1  instruction-fetch request; held high until fetch_ack.
- fetch_addr  in  16  fetch word address; stable while fetch_req is high.
- fetch_rdata  out  16  fetch read data; updated on fetch_ack and held otherwise.
- fetch_ack  out  1  one-cycle pulse marking fetch completion.
- data_req  in  1  data-port request; held high until data_ack.
- data_we  in  1  1 = write, 0 = read; stable while data_req is high.
- data_addr  in  16  data word address.
- data_wdata  in  16  write data.
- data_rdata  out  16  data read data; updated only on a read ack.
- data_ack  out  1  one-cycle completion pulse.
- spi_cs  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock, mode 0, clk/2.
- spi_io0_o, spi_io0_oe  out  1 each  MOSI drive and enable.
- spi_io0_i  in  1  unused.
- spi_io1_o, spi_io1_oe  out  1 each  tied 0.
- spi_io1_i  in  1  MISO.

## Operation
- States: IDLE, START, CMD, ADDR, DATA, DONE, CSHIGH.
- IDLE, arbitration:
  - If only one req is high, that port is granted.
  - If both are high, the port not granted last wins. The last_grant register resets to DATA, so fetch wins the first tie.
  - On grant, latch the port id, we (fetch is always read), address and wdata into a 40-bit shift register: {cmd, addr, wdata or 0}. Go to START.
  - Requests are sampled only in IDLE.
- START: assert spi_cs low and begin the SPI bit clock.
- CMD, ADDR, DATA: 8, 16 and 16 bits respectively, MSB first.
  - spi_io0_o is always the shift-register MSB.
  - spi_io0_oe is 1 in CMD and ADDR, and also in DATA when the transaction is a write. Otherwise it is 0.
  - On a read, DATA shifts spi_io1_i into a 16-bit capture register.
- DONE:
  - spi_cs goes high and sclk goes to 0.
  - Pulse the granted port's ack.
  - Load rdata for reads only; a data write leaves data_rdata unchanged.
  - Update last_grant. Go to CSHIGH.
- CSHIGH: count CS_HIGH_CYCLES−1 more cycles, then go to IDLE.
- Requester protocol:
  - Deassert req in the cycle after ack is sampled. CSHIGH guarantees that req is not re-sampled.
  - Dropping req mid-transaction is a protocol violation. The transaction still completes and ack still pulses.
- Reset, including mid-transaction:
  - Next cycle: spi_cs=1, spi_sclk=0, all oe=0, acks=0, rdata=0, state=IDLE, last_grant=DATA.
  - The in-flight transaction is abandoned with no ack.

## Timing
- Cycle N: req sampled high in IDLE, grant taken.
- Cycle N+1: spi_cs=0 and the first bit is presented with sclk=0.
- SPI bit k (k=0..39):
  - sclk=0 in cycle N+1+2k, with MOSI updated at the start of that cycle.
  - sclk=1 in cycle N+2+2k, when MISO is sampled on the clk edge where sclk rises.
- Cycle N+81: DONE. Ack is high, rdata is valid, spi_cs=1.
- Cycle N+81+CS_HIGH_CYCLES: the earliest next grant; spi_cs was high for exactly CS_HIGH_CYCLES cycles.
- Fetch-to-ack latency is 81 cycles. Back-to-back period is 81+CS_HIGH_CYCLES cycles (83 at default).
- Read data bit mapping: bit 15 of rdata is DATA bit 0, i.e. SPI bit 24.
- Reset values: spi_cs=1, spi_sclk=0, all *_oe=0, *_o=0, acks=0, rdata=0.

## Test plan
- Fetch read, addr 0x1234, memory model returns 0xABCD:
  - MOSI shows 0x03 then 0x1234.
  - io0_oe drops for the DATA phase.
  - fetch_ack is high at N+81 with fetch_rdata=0xABCD.
  - data_ack stays 0.
- Data write, addr 0xFFFF, wdata 0x5A5A:
  - MOSI shows 0x02, 0xFFFF, 0x5A5A, with io0_oe=1 for all 40 bits.
  - data_ack is high at N+81.
  - data_rdata is unchanged from its prior value.
- Both req held continuously from reset release:
  - Grants alternate fetch, data, fetch, data.
  - Ack spacing is 83 cycles and spi_cs is high ≥2 cycles between transactions.
- rst asserted in the ADDR phase:
  - Next cycle: spi_cs=1, sclk=0, oe=0, and no ack.
  - With fetch_req still high, a fresh fetch starts and acks 81 cycles after grant.
- Data read with CS_HIGH_CYCLES=4, model returns 0x0001:
  - data_rdata=0x0001 on data_ack.
  - The next grant is no earlier than 4 cycles of CS high.
- fetch_req dropped mid-transaction: the transaction completes, fetch_ack pulses once, and the block returns to IDLE with no retry.

Source files
------------

// File: rtl/spi_mem_arbiter_if.sv
// spi_mem_arbiter_if: fetch and data request/ack bus; master = core side, slave = arbiter side
interface spi_mem_arbiter_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_rdata;
  logic        fetch_ack;
  logic        data_req;
  logic        data_we;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic        data_ack;
  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    input  fetch_rdata, fetch_ack, data_rdata, data_ack
  );
  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
    output fetch_rdata, fetch_ack, data_rdata, data_ack
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: round-robin fetch/data arbiter driving one SPI memory (0x03 read, 0x02 write, 16b addr/word); ports clk, rst, bus (slave), spi_cs/sclk/io0/io1 pads
module spi_mem_arbiter #(
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  spi_mem_arbiter_if.slave bus,
  output logic spi_cs,
  output logic spi_sclk,
  output logic spi_io0_o,
  output logic spi_io0_oe,
  input  logic spi_io0_i,
  output logic spi_io1_o,
  output logic spi_io1_oe,
  input  logic spi_io1_i
);
  typedef enum logic [2:0] {IDLE, START, CMD, ADDR, DATA, DONE, CSHIGH} state_t;
  state_t state, state_n;
  logic [39:0] sr;
  logic [15:0] cap;
  logic [15:0] cs_cnt;
  logic [5:0]  cnt;
  logic        sclk, port, we, last_grant;
  logic        any_req, grant_data, unused_io0;
  // port encoding: 0 = fetch, 1 = data; on a tie the port not granted last wins
  assign any_req    = bus.fetch_req | bus.data_req;
  assign grant_data = bus.data_req & (~bus.fetch_req | ~last_grant);
  assign unused_io0 = spi_io0_i;
  assign spi_cs     = (state == IDLE) | (state == DONE) | (state == CSHIGH);
  assign spi_sclk   = sclk;
  assign spi_io0_o  = ~spi_cs & sr[39];
  assign spi_io0_oe = (state == START) | (state == CMD) | (state == ADDR) | ((state == DATA) & we);
  assign spi_io1_o  = 1'b0;
  assign spi_io1_oe = 1'b0;
  assign bus.fetch_ack = (state == DONE) & ~port;
  assign bus.data_ack  = (state == DONE) & port;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:            state_n = any_req ? START : IDLE;
      START:           state_n = CMD;
      CMD, ADDR, DATA: state_n = !sclk ? state : cnt == 6'd39 ? DONE : cnt == 6'd23 ? DATA : cnt == 6'd7 ? ADDR : state;
      DONE:            state_n = CSHIGH;
      CSHIGH:          state_n = cs_cnt == 16'd0 ? IDLE : CSHIGH;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cap <= '0;
      cs_cnt <= '0;
      cnt <= '0;
      sclk <= 1'b0;
      port <= 1'b0;
      we <= 1'b0;
      last_grant <= 1'b1;
      bus.fetch_rdata <= '0;
      bus.data_rdata <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (any_req) begin
          port <= grant_data;
          we   <= grant_data & bus.data_we;
          sr   <= !grant_data ? {8'h03, bus.fetch_addr, 16'h0000} :
                  bus.data_we ? {8'h02, bus.data_addr, bus.data_wdata} : {8'h03, bus.data_addr, 16'h0000};
          cnt  <= '0;
          sclk <= 1'b0;
        end
        START, CMD, ADDR, DATA: begin
          sclk <= ~sclk;
          // MISO is taken on the rising sclk edge; the capture keeps the last 16 bits, i.e. the DATA phase
          if (!sclk) cap <= {cap[14:0], spi_io1_i};
          else begin
            sr  <= {sr[38:0], 1'b0};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd39 && !port) bus.fetch_rdata <= cap;
            if (cnt == 6'd39 && port && !we) bus.data_rdata <= cap;
          end
        end
        DONE: begin
          last_grant <= port;
          cs_cnt <= 16'(CS_HIGH_CYCLES - 2);
        end
        CSHIGH: cs_cnt <= cs_cnt - 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: directed and randomized checks of spi_mem_arbiter against a transaction-level model and an SPI memory model
module tb_spi_mem_arbiter;
  localparam int CSH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_cs, spi_sclk, spi_io0_o, spi_io0_oe, spi_io1_o, spi_io1_oe;
  logic spi_io0_i = 1'b0;
  logic miso = 1'b0;
  spi_mem_arbiter_if bus ();
  spi_mem_arbiter #(.CS_HIGH_CYCLES(CSH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_io0_o(spi_io0_o), .spi_io0_oe(spi_io0_oe), .spi_io0_i(spi_io0_i),
    .spi_io1_o(spi_io1_o), .spi_io1_oe(spi_io1_oe), .spi_io1_i(miso)
  );
  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] ref_drd;
  logic        ref_last;
  int checks = 0;
  int errors = 0;

  // SPI memory model: collects MOSI on sclk rising, answers reads MSB first, commits writes after 40 bits
  int bitn = 0;
  logic prev_sclk = 1'b0;
  logic [39:0] mosi_w, oe_w, last_mosi, last_oe;
  logic [15:0] rd;
  int lows = 0;
  int facks = 0;
  int cs_run = 0;
  int runs[$];
  always @(negedge clk) begin
    if (spi_cs) begin
      bitn = 0;
      cs_run++;
    end else begin
      if (cs_run > 0) runs.push_back(cs_run);
      cs_run = 0;
      lows++;
      if (spi_sclk && !prev_sclk) begin
        mosi_w = {mosi_w[38:0], spi_io0_o};
        oe_w = {oe_w[38:0], spi_io0_oe};
        bitn++;
        if (bitn == 24) rd = mem[mosi_w[15:0]];
        if (bitn == 40) begin
          last_mosi = mosi_w;
          last_oe = oe_w;
          if (mosi_w[39:32] == 8'h02) mem[mosi_w[31:16]] = mosi_w[15:0];
        end
      end
    end
    if (bus.fetch_ack) facks++;
    miso = (bitn >= 24 && bitn < 40) ? rd[15 - (bitn - 24)] : 1'b0;
    prev_sclk = spi_sclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_any_ack(output int lat, output int port);
    lat = 0;
    port = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.fetch_ack) begin port = 0; break; end
      if (bus.data_ack) begin port = 1; break; end
    end
  endtask

  task automatic serve(input int p, input int exp_lat, input logic [15:0] fa, input logic [15:0] da,
                       input logic [15:0] dw, input logic dwe);
    int lat, got;
    wait_any_ack(lat, got);
    check("grant_port", got, p);
    check("ack_latency", lat, exp_lat);
    check("one_ack_only", {bus.fetch_ack, bus.data_ack}, p == 0 ? 2'b10 : 2'b01);
    if (p == 0) check("fetch_rdata", bus.fetch_rdata, ref_mem[fa]);
    else if (dwe) begin
      check("write_keeps_rdata", bus.data_rdata, ref_drd);
      check("mem_written", mem[da], dw);
      ref_mem[da] = dw;
    end else begin
      check("data_rdata", bus.data_rdata, ref_mem[da]);
      ref_drd = ref_mem[da];
    end
    ref_last = p[0];
  endtask

  task automatic release_port(input int p);
    @(posedge clk); #1;
    if (p == 0) bus.fetch_req = 1'b0;
    else bus.data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, f0, l0, lat, got;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h1234] = 16'hABCD;
    ref_mem[16'h1234] = 16'hABCD;
    ref_drd = 16'h0;
    ref_last = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", spi_cs, 1'b1);
    check("rst_sclk", spi_sclk, 1'b0);
    check("rst_oe", {spi_io0_oe, spi_io1_oe, spi_io0_o, spi_io1_o}, 4'b0);
    check("rst_acks", {bus.fetch_ack, bus.data_ack}, 2'b0);
    check("rst_rdata", {bus.fetch_rdata, bus.data_rdata}, 32'h0);
    rst = 1'b0;
    // fetch read 0x1234
    bus.fetch_addr = 16'h1234;
    bus.fetch_req = 1'b1;
    serve(0, 81, 16'h1234, 16'h0, 16'h0, 1'b0);
    check("fetch_mosi", last_mosi[39:16], 24'h031234);
    check("fetch_oe", last_oe, 40'hFF_FFFF_0000);
    release_port(0);
    // data read, then data write must leave data_rdata unchanged
    bus.data_addr = 16'h0042; bus.data_we = 1'b0; bus.data_req = 1'b1;
    serve(1, 81, 16'h0, 16'h0042, 16'h0, 1'b0);
    check("read_oe", last_oe, 40'hFF_FFFF_0000);
    release_port(1);
    bus.data_addr = 16'hFFFF; bus.data_wdata = 16'h5A5A; bus.data_we = 1'b1; bus.data_req = 1'b1;
    serve(1, 81, 16'h0, 16'hFFFF, 16'h5A5A, 1'b1);
    check("write_mosi", last_mosi, 40'h02_FFFF_5A5A);
    check("write_oe", last_oe, 40'hFF_FFFF_FFFF);
    release_port(1);
    // both requests held from reset release: fetch, data, fetch, data
    rst = 1'b1;
    ref_last = 1'b1;
    ref_drd = 16'h0;
    bus.fetch_addr = 16'h0005; bus.data_addr = 16'h0009; bus.data_we = 1'b0;
    bus.fetch_req = 1'b1; bus.data_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = runs.size();
    serve(0, 81, 16'h0005, 16'h0009, 16'h0, 1'b0);
    serve(1, 83, 16'h0005, 16'h0009, 16'h0, 1'b0);
    serve(0, 83, 16'h0005, 16'h0009, 16'h0, 1'b0);
    serve(1, 83, 16'h0005, 16'h0009, 16'h0, 1'b0);
    bus.fetch_req = 1'b0; bus.data_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = n0 + 1; i < runs.size(); i++) check("cs_high_gap", runs[i] >= CSH, 1'b1);
    // reset during the ADDR phase abandons the fetch, then it restarts cleanly
    bus.fetch_addr = 16'h0007; bus.fetch_req = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("addr_phase_cs", spi_cs, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", spi_cs, 1'b1);
    check("midrst_sclk", spi_sclk, 1'b0);
    check("midrst_oe", {spi_io0_oe, spi_io1_oe}, 2'b0);
    check("midrst_ack", {bus.fetch_ack, bus.data_ack}, 2'b0);
    check("midrst_rdata", {bus.fetch_rdata, bus.data_rdata}, 32'h0);
    rst = 1'b0;
    ref_last = 1'b1;
    ref_drd = 16'h0;
    serve(0, 81, 16'h0007, 16'h0, 16'h0, 1'b0);
    release_port(0);
    // fetch_req dropped mid-transaction: completes once, no retry
    bus.fetch_addr = 16'h0003; bus.fetch_req = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.fetch_req = 1'b0;
    wait_any_ack(lat, got);
    check("drop_port", got, 0);
    check("drop_latency", lat, 61);
    check("drop_rdata", bus.fetch_rdata, ref_mem[16'h0003]);
    ref_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    f0 = facks;
    l0 = lows;
    repeat (200) @(posedge clk);
    #1;
    check("drop_no_retry_ack", facks, f0);
    check("drop_no_retry_cs", lows, l0);
    // randomized traffic against the transaction-level model
    for (int s = 0; s < 14; s++) begin
      int mode, first;
      logic [15:0] fa, da, dw;
      logic dwe;
      mode = $urandom_range(0, 2);
      fa = 16'($urandom_range(0, 15));
      da = 16'($urandom_range(0, 15));
      dw = 16'($urandom);
      dwe = 1'($urandom_range(0, 1));
      bus.fetch_addr = fa; bus.data_addr = da; bus.data_wdata = dw; bus.data_we = dwe;
      bus.fetch_req = (mode != 1);
      bus.data_req = (mode != 0);
      first = mode == 2 ? (ref_last ? 0 : 1) : mode;
      serve(first, 81, fa, da, dw, dwe);
      if (mode == 2) begin
        @(posedge clk); #1;
        if (first == 0) bus.fetch_req = 1'b0;
        else bus.data_req = 1'b0;
        serve(1 - first, 82, fa, da, dw, dwe);
        release_port(1 - first);
      end else release_port(first);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
